// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the ADC128S022 scan sequencer: FSM states,
// channel addresses and the address-rotation / address-bit functions.
package adc_scan_pkg;

    typedef enum logic [1:0] {IDLE, FRAME, GAP} scan_state_e;

    localparam logic [2:0] CH5 = 3'd5;
    localparam logic [2:0] CH6 = 3'd6;
    localparam logic [2:0] CH7 = 3'd7;

    function automatic logic [2:0] next_ch(input logic [2:0] ch);
        case (ch)
            CH5:     return CH6;
            CH6:     return CH7;
            default: return CH5;
        endcase
    endfunction

    // Data shifted out in a frame belongs to the channel addressed one frame earlier.
    function automatic logic [2:0] prev_ch(input logic [2:0] ch);
        case (ch)
            CH6:     return CH5;
            CH7:     return CH6;
            default: return CH7;
        endcase
    endfunction

    // Bit presented on din ahead of sck rising edge number rise_n (1..16).
    function automatic logic din_bit(input logic [2:0] addr, input logic [4:0] rise_n);
        case (rise_n)
            5'd3:    return addr[2];
            5'd4:    return addr[1];
            5'd5:    return addr[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// One 16-clock ADC128S022 frame: cs_n/sck generation, address shift-out on din,
// 12-bit result shift-in from dout, one-cycle done pulse after the 16th rising edge.
module adc_spi_frame
    import adc_scan_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  addr_i,
    input  logic        dout_i,
    output logic        cs_n_o,
    output logic        sck_o,
    output logic        din_o,
    output logic        done_o,
    output logic        last_o,
    output logic [11:0] data_o
);

    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        din_q, din_d;
    logic [7:0]  hc_q, hc_d;
    logic [4:0]  ecnt_q, ecnt_d;
    logic [11:0] shreg_q, shreg_d;
    logic [2:0]  addr_q, addr_d;
    logic        done_q, done_d;
    logic        half_end;

    assign half_end = (hc_q == 8'(CLK_DIV - 1));

    always_comb begin
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        din_d   = din_q;
        hc_d    = hc_q;
        ecnt_d  = ecnt_q;
        shreg_d = shreg_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        if (start_i && cs_n_q) begin
            // cs_n and the first sck fall coincide; din for rising edge 1 is 0
            cs_n_d  = 1'b0;
            sck_d   = 1'b0;
            din_d   = 1'b0;
            hc_d    = '0;
            ecnt_d  = '0;
            shreg_d = '0;
            addr_d  = addr_i;
        end else if (!cs_n_q) begin
            if (!half_end) begin
                hc_d = hc_q + 8'd1;
            end else begin
                hc_d = '0;
                if (!sck_q) begin
                    sck_d   = 1'b1;
                    ecnt_d  = ecnt_q + 5'd1;
                    shreg_d = {shreg_q[10:0], dout_i};
                    done_d  = (ecnt_q == 5'd15);
                end else if (ecnt_q == 5'd16) begin
                    cs_n_d = 1'b1;
                end else begin
                    sck_d = 1'b0;
                    din_d = din_bit(addr_q, ecnt_q + 5'd1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b1;
            din_q   <= 1'b0;
            hc_q    <= '0;
            ecnt_q  <= '0;
            shreg_q <= '0;
            addr_q  <= CH5;
            done_q  <= 1'b0;
        end else begin
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            din_q   <= din_d;
            hc_q    <= hc_d;
            ecnt_q  <= ecnt_d;
            shreg_q <= shreg_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign cs_n_o = cs_n_q;
    assign sck_o  = sck_q;
    assign din_o  = din_q;
    assign done_o = done_q;
    assign data_o = shreg_q;
    assign last_o = !cs_n_q && half_end && sck_q && (ecnt_q == 5'd16);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Continuous 5/6/7 scan of an ADC128S022 with a prime frame after reset/idle.
// Optional ADC_AVG_EN: each channel output is the mean of the last two raw samples.
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int GAP_CYCLES = 50
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sck,
    output logic        adc_din,
    output logic [11:0] ch5,
    output logic [11:0] ch6,
    output logic [11:0] ch7,
    output logic        scan_valid,
    output logic        busy
);

    scan_state_e      state_q, state_d;
    logic [7:0]       gap_q, gap_d;
    logic [2:0]       next_addr_q, next_addr_d;
    logic [2:0]       data_ch_q, data_ch_d;
    logic             prime_q, prime_d;
    logic             frame_prime_q, frame_prime_d;
    logic [2:0][11:0] ch_q, ch_d;
    logic             sv_q, sv_d;
    logic             start, frame_done, frame_last;
    logic [11:0]      frame_data, res;
    logic [1:0]       idx;

    adc_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
        .clk_i   (clk_50),
        .rst_i   (rst),
        .start_i (start),
        .addr_i  (next_addr_q),
        .dout_i  (adc_dout),
        .cs_n_o  (adc_cs_n),
        .sck_o   (adc_sck),
        .din_o   (adc_din),
        .done_o  (frame_done),
        .last_o  (frame_last),
        .data_o  (frame_data)
    );

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        next_addr_d   = next_addr_q;
        data_ch_d     = data_ch_q;
        prime_d       = prime_q;
        frame_prime_d = frame_prime_q;
        start         = 1'b0;
        case (state_q)
            IDLE:  if (enable) start = 1'b1;
            FRAME: if (frame_last) begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        prime_d     = 1'b1;
                        next_addr_d = CH5;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d       = FRAME;
            next_addr_d   = next_ch(next_addr_q);
            data_ch_d     = prev_ch(next_addr_q);
            frame_prime_d = prime_q;
            prime_d       = 1'b0;
        end
    end

    assign idx = (data_ch_q == CH5) ? 2'd0 : (data_ch_q == CH6) ? 2'd1 : 2'd2;

`ifdef ADC_AVG_EN
    logic [2:0][11:0] raw_q, raw_d;
    logic [2:0]       have_q, have_d;
    logic [12:0]      sum;

    assign sum = {1'b0, raw_q[idx]} + {1'b0, frame_data};
    assign res = have_q[idx] ? sum[12:1] : frame_data;

    always_comb begin
        raw_d  = raw_q;
        have_d = have_q;
        // history restarts with every prime so stale samples never blend in
        if (start && prime_q) have_d = '0;
        if (frame_done && !frame_prime_q) begin
            raw_d[idx]  = frame_data;
            have_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            raw_q  <= '0;
            have_q <= '0;
        end else begin
            raw_q  <= raw_d;
            have_q <= have_d;
        end
    end
`else
    assign res = frame_data;
`endif

    always_comb begin
        ch_d = ch_q;
        sv_d = 1'b0;
        if (frame_done && !frame_prime_q) begin
            ch_d[idx] = res;
            sv_d      = (idx == 2'd2);
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q       <= IDLE;
            gap_q         <= '0;
            next_addr_q   <= CH5;
            data_ch_q     <= CH7;
            prime_q       <= 1'b1;
            frame_prime_q <= 1'b1;
            ch_q          <= '0;
            sv_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            next_addr_q   <= next_addr_d;
            data_ch_q     <= data_ch_d;
            prime_q       <= prime_d;
            frame_prime_q <= frame_prime_d;
            ch_q          <= ch_d;
            sv_q          <= sv_d;
        end
    end

    assign ch5        = ch_q[0];
    assign ch6        = ch_q[1];
    assign ch7        = ch_q[2];
    assign scan_valid = sv_q;
    assign busy       = (state_q != IDLE);

endmodule
